// File: rtl/mc_ctrl_fsm_if.sv
// Unified memory port shared by instruction fetch and load/store.
// The sequencer is the master; the memory answers with mem_ack.
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset.
// Issues per-step enables, traps on illegal opcodes or memory timeouts, counts retirements.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 branch_taken,
    mc_ctrl_fsm_if.master        mem,
    output logic                 IR_we,
    output logic                 MDR_we,
    output logic                 PC_we,
    output logic                 RF_we,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 2);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    state_t                 state_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic [1:0]             trap_cause_q;
    logic [INSTRET_W-1:0]   instret_q;

    logic req;
    logic we;
    logic addr_sel;
    logic acked;
    logic timeout;
    logic legal;
    logic is_load;
    logic is_store;
    logic unused_branch_taken;

    // The branch decision is taken by the NPC mux; the sequencer only retires the branch.
    assign unused_branch_taken = branch_taken;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign legal    = (opcode == OP_R)      || (opcode == OP_I)    || is_load ||
                      is_store              || (opcode == OP_BRANCH) ||
                      (opcode == OP_JAL)    || (opcode == OP_JALR) || (opcode == OP_LUI);

    always_comb begin
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        IR_we    = 1'b0;
        MDR_we   = 1'b0;
        PC_we    = 1'b0;
        RF_we    = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                req   = 1'b1;
                IR_we = mem.mem_ack;
            end
            S_EXEC: PC_we = (opcode == OP_BRANCH);
            S_MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = is_store;
                MDR_we   = mem.mem_ack && is_load;
                PC_we    = mem.mem_ack && is_store;
            end
            S_WB: begin
                RF_we = 1'b1;
                PC_we = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign acked   = req && mem.mem_ack;
    // Limit hit on the un-acked cycle that would bring the count to TIMEOUT-1; an ack wins.
    assign timeout = req && !mem.mem_ack && (wait_cnt_q == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST;
            wait_cnt_q   <= '0;
            trap_cause_q <= '0;
            instret_q    <= '0;
        end else begin
            if (PC_we)
                instret_q <= instret_q + 1'b1;

            if (req && !acked)
                wait_cnt_q <= wait_cnt_q + 1'b1;
            else
                wait_cnt_q <= '0;

            case (state_q)
                S_RST: state_q <= S_FETCH;
                S_FETCH: begin
                    if (acked) begin
                        state_q <= S_DECODE;
                    end else if (timeout) begin
                        state_q <= S_TRAP;
                        if (trap_cause_q == 2'b00) trap_cause_q <= 2'b10;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        if (trap_cause_q == 2'b00) trap_cause_q <= 2'b01;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store)     state_q <= S_MEM;
                    else if (opcode == OP_BRANCH) state_q <= S_FETCH;
                    else                          state_q <= S_WB;
                end
                S_MEM: begin
                    if (acked) begin
                        state_q <= is_load ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        state_q <= S_TRAP;
                        if (trap_cause_q == 2'b00) trap_cause_q <= 2'b10;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_RST;
            endcase
        end
    end

    assign mem.mem_req      = req;
    assign mem.mem_we       = we;
    assign mem.mem_addr_sel = addr_sel;
    assign trap_cause       = trap_cause_q;
    assign instret          = instret_q;

endmodule
